fp_mul_div_seq: RTL and testbench

Parametrised sequential floating-point multiply/divide unit for the FPU datapath. It generalises the 16-bit multiply/divide circuit to any EXP_W/MAN_W format and adds several behaviours: a start/busy/done handshake, a real mantissa product, an iterative restoring divider, normalisation, and optional round-to-nearest-even. It sits beside the add/sub unit and shares the 2-bit overflow/underflow flag encoding.

---
 rtl/fp_mul_div_seq.sv | 264 ++++++++++++++++++++++++++
 tb/tb_fp_mul_div_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_div_seq.sv
// Sequential floating-point multiply/divide unit, parametrised on EXP_W/MAN_W.
// Handshake: start (sampled in idle) -> busy -> one-cycle done with result/of_uf.
// Multiply uses a single-cycle mantissa product; divide is a restoring divider
// producing one quotient bit per cycle.
// Build option: define FPU_ROUND_EN for round-to-nearest-even; otherwise truncate.
// of_uf encoding: 00 ok, 10 overflow, 01 underflow, 11 divide-by-zero.

module fp_mul_div_seq #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    localparam int unsigned W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mul_div,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [1:0]   of_uf
);

    localparam int unsigned EW2  = EXP_W + 2;      // signed working exponent width
    localparam int unsigned PW   = 2 * MAN_W + 2;  // mantissa product width
    localparam int unsigned QW   = MAN_W + 3;      // quotient bits produced
    localparam int unsigned RW   = MAN_W + 2;      // partial remainder width
    localparam int unsigned CntW = $clog2(QW);

    localparam logic signed [EW2-1:0] BiasE = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] MaxE  = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] OneE  = EW2'(1);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StMul,
        StDiv,
        StNorm,
        StRound,
        StDone
    } stateT;

    stateT stateQ, stateD;

    // Latched operands and working registers
    logic [W-1:0]            xQ, yQ;
    logic                    mulDivQ;
    logic signed [EW2-1:0]   expQ;
    logic [PW-1:0]           prodQ;
    logic [QW-1:0]           quoQ;
    logic [RW-1:0]           remQ;
    logic [CntW-1:0]         cntQ;
    logic [MAN_W-1:0]        manQ;
    logic                    guardQ, stickyQ;
    logic [W-1:0]            resultQ;
    logic [1:0]              ofUfQ;

    // Operand decode
    logic                    signR;
    logic                    xZero, yZero;
    logic [MAN_W:0]          mx, my;
    logic signed [EW2-1:0]   exS, eyS;

    // Normalisation and rounding results
    logic [MAN_W-1:0]        normMan;
    logic                    normGuard, normSticky;
    logic signed [EW2-1:0]   normExp;
    logic                    roundUp;
    logic [MAN_W:0]          manSum;
    logic [MAN_W-1:0]        finalMan;
    logic signed [EW2-1:0]   finalExp;
    logic [W-1:0]            rndResult;
    logic [1:0]              rndFlags;

    // Decode the latched operands: sign, zero flags, hidden-bit mantissas, exponents
    always_comb begin
        signR = xQ[W-1] ^ yQ[W-1];
        xZero = (xQ[W-2:MAN_W] == '0);
        yZero = (yQ[W-2:MAN_W] == '0);
        mx    = {1'b1, xQ[MAN_W-1:0]};
        my    = {1'b1, yQ[MAN_W-1:0]};
        exS   = {2'b00, xQ[W-2:MAN_W]};
        eyS   = {2'b00, yQ[W-2:MAN_W]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:  if (start) stateD = StCheck;
            StCheck: begin
                // Any zero operand (including divide-by-zero) short-circuits to done
                if (xZero || yZero) begin
                    stateD = StDone;
                end else begin
                    stateD = mulDivQ ? StDiv : StMul;
                end
            end
            StMul:   stateD = StNorm;
            StDiv:   if (cntQ == CntW'(QW - 1)) stateD = StNorm;
            StNorm:  stateD = StRound;
            StRound: stateD = StDone;
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    // Outputs decoded from the state and the held result registers
    always_comb begin
        busy   = (stateQ != StIdle);
        done   = (stateQ == StDone);
        result = resultQ;
        of_uf  = ofUfQ;
    end

    // One-position normalisation of the product or quotient
    always_comb begin
        normMan    = '0;
        normGuard  = 1'b0;
        normSticky = 1'b0;
        normExp    = expQ;
        if (!mulDivQ) begin
            if (prodQ[PW-1]) begin
                // Product in [2,4): drop one more bit and bump the exponent
                normMan    = prodQ[PW-2:MAN_W+1];
                normGuard  = prodQ[MAN_W];
                normSticky = |prodQ[MAN_W-1:0];
                normExp    = expQ + OneE;
            end else begin
                normMan    = prodQ[PW-3:MAN_W];
                normGuard  = prodQ[MAN_W-1];
                normSticky = |prodQ[MAN_W-2:0];
            end
        end else begin
            if (quoQ[QW-1]) begin
                normMan    = quoQ[QW-2:2];
                normGuard  = quoQ[1];
                normSticky = quoQ[0] | (remQ != '0);
            end else begin
                // Quotient in (0.5,1): shift left and drop the exponent
                normMan    = quoQ[QW-3:1];
                normGuard  = quoQ[0];
                normSticky = (remQ != '0);
                normExp    = expQ - OneE;
            end
        end
    end

    // Rounding, carry renormalisation and exponent range check
    always_comb begin
`ifdef FPU_ROUND_EN
        roundUp = guardQ & (stickyQ | manQ[0]);
`else
        roundUp = 1'b0;
`endif
        manSum   = {1'b0, manQ} + {{MAN_W{1'b0}}, roundUp};
        finalMan = manSum[MAN_W-1:0];
        finalExp = expQ;
        if (manSum[MAN_W]) begin
            // 1.11..1 + ulp = 10.0: mantissa wraps to zero, exponent steps up
            finalMan = '0;
            finalExp = expQ + OneE;
        end
        if (finalExp > MaxE) begin
            rndResult = {signR, {(W-1){1'b1}}};
            rndFlags  = 2'b10;
        end else if (finalExp < OneE) begin
            rndResult = {signR, {(W-1){1'b0}}};
            rndFlags  = 2'b01;
        end else begin
            rndResult = {signR, finalExp[EXP_W-1:0], finalMan};
            rndFlags  = 2'b00;
        end
    end

`ifndef FPU_ROUND_EN
    // Truncation discards guard and sticky
    logic unusedRnd;
    assign unusedRnd = guardQ ^ stickyQ;
`endif

    // Datapath registers: operand latch, mantissa arithmetic, result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            xQ      <= '0;
            yQ      <= '0;
            mulDivQ <= 1'b0;
            expQ    <= '0;
            prodQ   <= '0;
            quoQ    <= '0;
            remQ    <= '0;
            cntQ    <= '0;
            manQ    <= '0;
            guardQ  <= 1'b0;
            stickyQ <= 1'b0;
            resultQ <= '0;
            ofUfQ   <= 2'b00;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (start) begin
                        xQ      <= x;
                        yQ      <= y;
                        mulDivQ <= mul_div;
                    end
                end
                StCheck: begin
                    if (mulDivQ && yZero) begin
                        resultQ <= {signR, {(W-1){1'b1}}};
                        ofUfQ   <= 2'b11;
                    end else if (xZero || yZero) begin
                        resultQ <= {signR, {(W-1){1'b0}}};
                        ofUfQ   <= 2'b00;
                    end else begin
                        expQ <= mulDivQ ? (exS - eyS + BiasE) : (exS + eyS - BiasE);
                    end
                    cntQ <= '0;
                    quoQ <= '0;
                    remQ <= RW'(mx);
                end
                StMul: begin
                    prodQ <= PW'(mx) * PW'(my);
                end
                StDiv: begin
                    // Restoring step: subtract when it fits, then shift the remainder
                    if (remQ >= RW'(my)) begin
                        quoQ <= {quoQ[QW-2:0], 1'b1};
                        remQ <= (remQ - RW'(my)) << 1;
                    end else begin
                        quoQ <= {quoQ[QW-2:0], 1'b0};
                        remQ <= remQ << 1;
                    end
                    cntQ <= cntQ + CntW'(1);
                end
                StNorm: begin
                    manQ    <= normMan;
                    guardQ  <= normGuard;
                    stickyQ <= normSticky;
                    expQ    <= normExp;
                end
                StRound: begin
                    resultQ <= rndResult;
                    ofUfQ   <= rndFlags;
                end
                StDone: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_div_seq.sv
// Scoreboard bench for fp_mul_div_seq at the default 16-bit format.
// Expected results are queued when an operation is accepted and checked when done pulses.

module tb_fp_mul_div_seq;

    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int W       = 1 + EXP_W + MAN_W;
    localparam int LatSpec = 2;
    localparam int LatMul  = 5;
    localparam int LatDiv  = MAN_W + 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         mul_div;
    logic [W-1:0] x, y;
    logic         busy, done;
    logic [W-1:0] result;
    logic [1:0]   of_uf;

    fp_mul_div_seq #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mul_div(mul_div),
        .x      (x),
        .y      (y),
        .busy   (busy),
        .done   (done),
        .result (result),
        .of_uf  (of_uf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [1:0]   flg;
        int           cyc;
    } expT;

    expT   sbQ[$];
    expT   monE;
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    int    doneSeen = 0;
    string curTag = "init";

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            doneSeen++;
            if (sbQ.size() == 0) begin
                checkVal({curTag, ".spuriousDone"}, 32'd1, 32'd0);
            end else begin
                monE = sbQ.pop_front();
                checkVal({curTag, ".result"}, 32'(result), 32'(monE.res));
                checkVal({curTag, ".of_uf"}, 32'(of_uf), 32'(monE.flg));
                checkVal({curTag, ".doneCycle"}, cyc, monE.cyc);
            end
        end
    end

    task automatic pushExp(input logic [W-1:0] er, input logic [1:0] ef, input int doneCyc);
        expT e;
        e.res = er;
        e.flg = ef;
        e.cyc = doneCyc;
        sbQ.push_back(e);
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) checkVal({tag, ".timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic doOp(input string tag, input logic md, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic [1:0] ef,
                        input int lat, input bit midStart);
        @(negedge clk);
        curTag  = tag;
        start   = 1'b1;
        mul_div = md;
        x       = a;
        y       = b;
        @(posedge clk);
        #1;
        pushExp(er, ef, cyc + lat - 1);
        start = 1'b0;
        checkVal({tag, ".busy"}, 32'(busy), 32'd1);
        if (midStart) begin
            // A second request while busy must not be accepted
            @(negedge clk);
            start = 1'b1;
            x     = 16'h7800;
            y     = 16'h7800;
            @(negedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        waitIdle(tag);
        checkVal({tag, ".heldResult"}, 32'(result), 32'(er));
        checkVal({tag, ".heldFlags"}, 32'(of_uf), 32'(ef));
        checkVal({tag, ".pending"}, sbQ.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] expRound;
        int           acc;
        int           snap;
`ifdef FPU_ROUND_EN
        expRound = 16'h4082;
`else
        expRound = 16'h4081;
`endif
        reset   = 1'b1;
        start   = 1'b0;
        mul_div = 1'b0;
        x       = '0;
        y       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("reset.busy", 32'(busy), 32'd0);
        checkVal("reset.done", 32'(done), 32'd0);
        checkVal("reset.result", 32'(result), 32'd0);
        checkVal("reset.of_uf", 32'(of_uf), 32'd0);
        reset = 1'b0;

        doOp("mul1p5x2",   1'b0, 16'h3E00, 16'h4000, 16'h4200, 2'b00, LatMul, 1'b1);
        doOp("div3by2",    1'b1, 16'h4200, 16'h4000, 16'h3E00, 2'b00, LatDiv, 1'b0);
        doOp("divM1by3",   1'b1, 16'hBC00, 16'h4200, 16'hB555, 2'b00, LatDiv, 1'b0);
        doOp("divM1byM1",  1'b1, 16'hBC00, 16'hBC00, 16'h3C00, 2'b00, LatDiv, 1'b0);
        doOp("mulRound",   1'b0, 16'h3E01, 16'h3E01, expRound, 2'b00, LatMul, 1'b0);
        doOp("mulOvf",     1'b0, 16'h7800, 16'h7800, 16'h7FFF, 2'b10, LatMul, 1'b0);
        doOp("mulUnf",     1'b0, 16'h0400, 16'h8400, 16'h8000, 2'b01, LatMul, 1'b0);
        doOp("divByZero",  1'b1, 16'h3C00, 16'h0000, 16'h7FFF, 2'b11, LatSpec, 1'b0);
        doOp("mulZero",    1'b0, 16'h0000, 16'hC000, 16'h8000, 2'b00, LatSpec, 1'b0);
        doOp("divZeroZero",1'b1, 16'h0000, 16'h0000, 16'h7FFF, 2'b11, LatSpec, 1'b0);
        doOp("mulFlush",   1'b0, 16'h03FF, 16'h4000, 16'h0000, 2'b00, LatSpec, 1'b0);

        // Back-to-back with start held high: the start seen during done is ignored
        @(negedge clk);
        curTag  = "b2b";
        start   = 1'b1;
        mul_div = 1'b0;
        x       = 16'h3E00;
        y       = 16'h4000;
        @(posedge clk);
        #1;
        acc = cyc;
        pushExp(16'h4200, 2'b00, acc + LatMul - 1);
        repeat (LatMul) @(negedge clk);
        x = 16'h4000;
        y = 16'h4000;
        pushExp(16'h4400, 2'b00, acc + LatMul + 1 + LatMul - 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle("b2b");
        checkVal("b2b.pending", sbQ.size(), 0);

        // Reset during the fifth divide iteration aborts the operation
        @(negedge clk);
        curTag  = "abort";
        start   = 1'b1;
        mul_div = 1'b1;
        x       = 16'h4200;
        y       = 16'h4000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkVal("abort.busy", 32'(busy), 32'd0);
        checkVal("abort.done", 32'(done), 32'd0);
        checkVal("abort.result", 32'(result), 32'd0);
        checkVal("abort.of_uf", 32'(of_uf), 32'd0);
        reset = 1'b0;
        snap  = doneSeen;
        repeat (25) @(negedge clk);
        checkVal("abort.noDone", doneSeen, snap);

        doOp("afterAbort", 1'b0, 16'h3E00, 16'h4000, 16'h4200, 2'b00, LatMul, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
